// File: rtl/bht_update_ctrl_if.sv
// Lookup (IF side) and resolution (EX side) handshake bundle for bht_update_ctrl.
// master = core pipeline, slave = BHT sequencer.
interface bht_update_ctrl_if #(
  parameter int unsigned IDX_W = 3
) ();
  logic             lookup_valid;
  logic [IDX_W-1:0] lookup_idx;
  logic             lookup_ready;
  logic             pred_valid;
  logic             pred_taken;
  logic             upd_valid;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_taken;
  logic             upd_pred;
  logic             upd_ready;

  modport master (
    output lookup_valid, lookup_idx, upd_valid, upd_idx, upd_taken, upd_pred,
    input  lookup_ready, pred_valid, pred_taken, upd_ready
  );

  modport slave (
    input  lookup_valid, lookup_idx, upd_valid, upd_idx, upd_taken, upd_pred,
    output lookup_ready, pred_valid, pred_taken, upd_ready
  );
endinterface

// File: rtl/bht_update_ctrl.sv
// Single-port 2-bit-counter BHT sequencer: clears the table after reset, serves lookups,
// queues resolutions and drains them when the port is free. BHT_STATS_EN adds mispred_cnt.
module bht_update_ctrl #(
  parameter int unsigned IDX_W      = 3,
  parameter int unsigned QDEPTH     = 2,
  parameter logic [1:0]  INIT_STATE = 2'b01
) (
  input  logic                    clk,
  input  logic                    arst_n,
  bht_update_ctrl_if.slave        bus,
  output logic                    init_busy
`ifdef BHT_STATS_EN
  ,
  output logic [15:0]             mispred_cnt
`endif
);

  localparam int unsigned DEPTH = 1 << IDX_W;
  localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(QDEPTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(QDEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e           state_q;
  logic [IDX_W-1:0] init_ptr_q;
  logic             init_busy_q;

  logic [1:0]       table_q  [DEPTH];
  logic [IDX_W-1:0] q_idx_q  [QDEPTH];
  logic             q_taken_q[QDEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rdy_q, rdy_d;
  logic             pred_valid_q, pred_valid_d;
  logic             pred_taken_q, pred_taken_d;

  logic             run_s;
  logic             run_next_s;
  logic             lookup_acc_s;
  logic             upd_acc_s;
  logic             drain_s;
  logic [IDX_W-1:0] drain_idx_s;
  logic             drain_taken_s;
  logic [1:0]       drain_ctr_s;

  function automatic logic [1:0] sat_ctr(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    if (taken) begin
      if (ctr == 2'b11) res = 2'b11;
      else              res = ctr + 2'b01;
    end else begin
      if (ctr == 2'b00) res = 2'b00;
      else              res = ctr - 2'b01;
    end
    return res;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    logic [PTR_W-1:0] res;
    if (ptr == LAST_PTR) res = '0;
    else                 res = ptr + PTR_W'(1);
    return res;
  endfunction

  // Table-clear sequencer: walks every entry once, then stays in RUN until reset.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q     <= ST_INIT;
      init_ptr_q  <= '0;
      init_busy_q <= 1'b1;
    end else begin
      case (state_q)
        ST_INIT: begin
          init_ptr_q <= init_ptr_q + IDX_W'(1);
          if (init_ptr_q == LAST_IDX) begin
            state_q     <= ST_RUN;
            init_busy_q <= 1'b0;
          end else begin
            state_q     <= ST_INIT;
            init_busy_q <= 1'b1;
          end
        end
        ST_RUN: begin
          state_q     <= ST_RUN;
          init_ptr_q  <= init_ptr_q;
          init_busy_q <= 1'b0;
        end
        default: begin
          state_q     <= ST_INIT;
          init_ptr_q  <= '0;
          init_busy_q <= 1'b1;
        end
      endcase
    end
  end

  // Port arbitration and queue bookkeeping; rdy_q is precomputed so ready never depends on inputs.
  always_comb begin
    run_s         = (state_q == ST_RUN);
    run_next_s    = run_s || ((state_q == ST_INIT) && (init_ptr_q == LAST_IDX));
    lookup_acc_s  = bus.lookup_valid && rdy_q;
    upd_acc_s     = bus.upd_valid && rdy_q;
    drain_s       = run_s && (count_q != '0) && (!rdy_q || !bus.lookup_valid);
    drain_idx_s   = q_idx_q[rd_ptr_q];
    drain_taken_s = q_taken_q[rd_ptr_q];
    drain_ctr_s   = sat_ctr(table_q[drain_idx_s], drain_taken_s);

    if (drain_s) rd_ptr_d = ptr_inc(rd_ptr_q);
    else         rd_ptr_d = rd_ptr_q;

    if (upd_acc_s) wr_ptr_d = ptr_inc(wr_ptr_q);
    else           wr_ptr_d = wr_ptr_q;

    case ({upd_acc_s, drain_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (run_next_s) rdy_d = (count_d != FULL_CNT);
    else            rdy_d = 1'b0;

    pred_valid_d = lookup_acc_s;
    if (lookup_acc_s) pred_taken_d = table_q[bus.lookup_idx][1];
    else              pred_taken_d = 1'b0;
  end

  // Control registers; reset empties the queue and drops any pending prediction.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      rdy_q        <= 1'b0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      rdy_q        <= rdy_d;
      pred_valid_q <= pred_valid_d;
      pred_taken_q <= pred_taken_d;
    end
  end

  // Table and queue storage; contents are rebuilt by INIT, so no reset values are needed.
  always_ff @(posedge clk) begin
    if (arst_n) begin
      if (state_q == ST_INIT) begin
        table_q[init_ptr_q] <= INIT_STATE;
      end else if (drain_s) begin
        table_q[drain_idx_s] <= drain_ctr_s;
      end
      if (upd_acc_s) begin
        q_idx_q[wr_ptr_q]   <= bus.upd_idx;
        q_taken_q[wr_ptr_q] <= bus.upd_taken;
      end
    end
  end

`ifdef BHT_STATS_EN
  logic [15:0] mispred_q;

  // Saturating count of accepted resolutions whose used prediction was wrong.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      mispred_q <= 16'h0000;
    end else if (upd_acc_s && (bus.upd_pred != bus.upd_taken) && (mispred_q != 16'hFFFF)) begin
      mispred_q <= mispred_q + 16'h0001;
    end else begin
      mispred_q <= mispred_q;
    end
  end

  assign mispred_cnt = mispred_q;
`else
  logic unused_upd_pred_s;
  assign unused_upd_pred_s = bus.upd_pred;
`endif

  assign bus.lookup_ready = rdy_q;
  assign bus.upd_ready    = rdy_q;
  assign bus.pred_valid   = pred_valid_q;
  assign bus.pred_taken   = pred_taken_q;
  assign init_busy        = init_busy_q;

endmodule

// File: tb/tb_bht_update_ctrl.sv
// Directed bench for bht_update_ctrl (IDX_W=3, QDEPTH=2, INIT_STATE=01); outputs are
// sampled and inputs driven on the falling edge. Stats checks compile under BHT_STATS_EN.
module tb_bht_update_ctrl;
  logic clk;
  logic arst_n;
  logic init_busy;
`ifdef BHT_STATS_EN
  logic [15:0] mispred_cnt;
`endif
  int checks = 0;
  int errors = 0;
  int busy;
  logic [2:0] v_idx [10];
  logic       v_tkn [10];

  bht_update_ctrl_if #(.IDX_W(3)) bus ();

  bht_update_ctrl #(.IDX_W(3), .QDEPTH(2), .INIT_STATE(2'b01)) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .bus         (bus),
    .init_busy   (init_busy)
`ifdef BHT_STATS_EN
    ,
    .mispred_cnt (mispred_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.lookup_valid = 1'b0;
    bus.upd_valid    = 1'b0;
  endtask

  task automatic lookup(input logic [2:0] idx, input logic exp_taken);
    bus.lookup_valid = 1'b1;
    bus.lookup_idx   = idx;
    tick();
    check("lookup_pred_valid", 32'(bus.pred_valid), 32'd1);
    check($sformatf("lookup_pred_taken_idx%0d", idx), 32'(bus.pred_taken), 32'(exp_taken));
    bus.lookup_valid = 1'b0;
  endtask

  task automatic send(input logic [2:0] idx, input logic taken, input logic pred);
    int guard = 0;
    bus.upd_valid = 1'b1;
    bus.upd_idx   = idx;
    bus.upd_taken = taken;
    bus.upd_pred  = pred;
    while (bus.upd_ready !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    if (guard >= 20) check("upd_ready_timeout", 32'(bus.upd_ready), 32'd1);
    tick();
  endtask

  initial begin
    v_idx = '{3'd5, 3'd5, 3'd5, 3'd5, 3'd7, 3'd7, 3'd7, 3'd7, 3'd2, 3'd2};
    v_tkn = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    arst_n = 1'b0;
    bus.lookup_valid = 1'b0;
    bus.lookup_idx   = 3'd0;
    bus.upd_valid    = 1'b0;
    bus.upd_idx      = 3'd0;
    bus.upd_taken    = 1'b0;
    bus.upd_pred     = 1'b0;

    // 1: reset state, INIT length, first lookup
    tick();
    tick();
    check("rst_init_busy", 32'(init_busy), 32'd1);
    check("rst_pred_valid", 32'(bus.pred_valid), 32'd0);
    check("rst_pred_taken", 32'(bus.pred_taken), 32'd0);
    check("rst_lookup_ready", 32'(bus.lookup_ready), 32'd0);
    check("rst_upd_ready", 32'(bus.upd_ready), 32'd0);
    arst_n = 1'b1;
    busy = 0;
    while (init_busy === 1'b1 && busy < 20) begin
      busy++;
      tick();
    end
    check("init_cycles", 32'(busy), 32'd8);
    check("run_lookup_ready", 32'(bus.lookup_ready), 32'd1);
    check("run_upd_ready", 32'(bus.upd_ready), 32'd1);
    lookup(3'd5, 1'b0);
    tick();
    check("idle_pred_valid", 32'(bus.pred_valid), 32'd0);

    // 2: saturating up then down on idx 2
    send(3'd2, 1'b1, 1'b0);
    send(3'd2, 1'b1, 1'b0);
    send(3'd2, 1'b1, 1'b0);
    idle();
    tick();
    tick();
    lookup(3'd2, 1'b1);
    send(3'd2, 1'b0, 1'b1);
    send(3'd2, 1'b0, 1'b1);
    send(3'd2, 1'b0, 1'b1);
    send(3'd2, 1'b0, 1'b1);
    idle();
    tick();
    tick();
    lookup(3'd2, 1'b0);
    send(3'd2, 1'b1, 1'b0);
    idle();
    tick();
    tick();
    lookup(3'd2, 1'b0);

    // 3: lookups win until the queue fills, then the head drains
    bus.lookup_valid = 1'b1;
    bus.lookup_idx   = 3'd0;
    bus.upd_valid    = 1'b1;
    bus.upd_idx      = 3'd3;
    bus.upd_taken    = 1'b1;
    bus.upd_pred     = 1'b0;
    tick();
    check("t3_a_pred_valid", 32'(bus.pred_valid), 32'd1);
    check("t3_a_pred_taken", 32'(bus.pred_taken), 32'd0);
    check("t3_a_upd_ready", 32'(bus.upd_ready), 32'd1);
    tick();
    check("t3_full_upd_ready", 32'(bus.upd_ready), 32'd0);
    check("t3_full_lookup_ready", 32'(bus.lookup_ready), 32'd0);
    check("t3_b_pred_valid", 32'(bus.pred_valid), 32'd1);
    bus.upd_valid = 1'b0;
    tick();
    check("t3_stall_pred_valid", 32'(bus.pred_valid), 32'd0);
    check("t3_after_drain_lookup_ready", 32'(bus.lookup_ready), 32'd1);
    check("t3_after_drain_upd_ready", 32'(bus.upd_ready), 32'd1);
    tick();
    check("t3_resume_pred_valid", 32'(bus.pred_valid), 32'd1);
    idle();
    tick();
    tick();
    lookup(3'd3, 1'b1);

    // 4: enqueue while draining keeps count, then FIFO order across wrap
    bus.lookup_valid = 1'b1;
    bus.lookup_idx   = 3'd0;
    bus.upd_valid    = 1'b1;
    bus.upd_idx      = 3'd4;
    bus.upd_taken    = 1'b0;
    tick();
    check("t4_one_upd_ready", 32'(bus.upd_ready), 32'd1);
    bus.lookup_valid = 1'b0;
    bus.upd_idx      = 3'd1;
    bus.upd_taken    = 1'b1;
    tick();
    check("t4_same_cycle_upd_ready", 32'(bus.upd_ready), 32'd1);
    bus.lookup_valid = 1'b1;
    bus.upd_idx      = 3'd6;
    bus.upd_taken    = 1'b1;
    tick();
    check("t4_count_two_full", 32'(bus.upd_ready), 32'd0);
    idle();
    tick();
    tick();
    tick();
    lookup(3'd1, 1'b1);
    lookup(3'd4, 1'b0);
    lookup(3'd6, 1'b1);
    for (int k = 0; k < 10; k++) begin
      bus.lookup_valid = (k % 2 == 1);
      bus.lookup_idx   = 3'd0;
      send(v_idx[k], v_tkn[k], 1'b0);
    end
    idle();
    tick();
    tick();
    tick();
    tick();
    lookup(3'd5, 1'b1);
    lookup(3'd7, 1'b0);
    lookup(3'd2, 1'b1);

    // 5: reset with two queued updates discards them and re-clears the table
    bus.lookup_valid = 1'b1;
    bus.lookup_idx   = 3'd0;
    send(3'd3, 1'b1, 1'b0);
    send(3'd3, 1'b1, 1'b0);
    check("t5_queue_full", 32'(bus.upd_ready), 32'd0);
    idle();
    arst_n = 1'b0;
    tick();
    arst_n = 1'b1;
    check("t5_rst_upd_ready", 32'(bus.upd_ready), 32'd0);
    check("t5_rst_pred_valid", 32'(bus.pred_valid), 32'd0);
`ifdef BHT_STATS_EN
    check("t6_rst_mispred", 32'(mispred_cnt), 32'd0);
`endif
    busy = 0;
    while (init_busy === 1'b1 && busy < 20) begin
      busy++;
      tick();
    end
    check("t5_init_cycles", 32'(busy), 32'd8);
    tick();
    tick();
    tick();
    for (int i = 0; i < 8; i++) lookup(3'(i), 1'b0);

`ifdef BHT_STATS_EN
    // 6: three mispredictions among five resolutions
    send(3'd1, 1'b1, 1'b0);
    send(3'd1, 1'b0, 1'b0);
    send(3'd2, 1'b1, 1'b1);
    send(3'd2, 1'b0, 1'b1);
    send(3'd3, 1'b1, 1'b0);
    idle();
    tick();
    check("t6_mispred_cnt", 32'(mispred_cnt), 32'd3);
    tick();
`endif

    send(3'd0, 1'b1, 1'b1);
    idle();
    tick();
    tick();
    lookup(3'd0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
